// File: rtl/cache_pkg.sv
// Shared helpers for the set-associative cache storage slice.
package cache_pkg;

    function automatic int unsigned idx_bits(input int unsigned num_sets);
        return (num_sets < 2) ? 1 : $clog2(num_sets);
    endfunction

    function automatic int unsigned way_bits(input int unsigned num_ways);
        return (num_ways < 2) ? 1 : $clog2(num_ways);
    endfunction

endpackage

// File: rtl/lru_age_set.sv
// True-LRU age vector for one set; applies an ordered list of touches per cycle.
module lru_age_set
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned NUM_TOUCH = 3,
    localparam int unsigned WAY_BITS = way_bits(NUM_WAYS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_TOUCH-1:0]          touch_en,
    input  logic [NUM_TOUCH*WAY_BITS-1:0] touch_way,
    output logic [NUM_WAYS*WAY_BITS-1:0]  ages,
    output logic [WAY_BITS-1:0]           lru_way
);

    logic [WAY_BITS-1:0] age_q [NUM_WAYS];
    logic [WAY_BITS-1:0] age_d [NUM_WAYS];
    logic [WAY_BITS-1:0] tw;
    logic [WAY_BITS-1:0] ta;

    // Touches compose in index order, each seeing the result of the previous one.
    always_comb begin
        age_d = age_q;
        tw    = '0;
        ta    = '0;
        for (int unsigned t = 0; t < NUM_TOUCH; t++) begin
            if (touch_en[t]) begin
                tw = touch_way[t*WAY_BITS +: WAY_BITS];
                ta = age_d[tw];
                for (int unsigned v = 0; v < NUM_WAYS; v++) begin
                    if (age_d[v] < ta) begin
                        age_d[v] = age_d[v] + WAY_BITS'(1);
                    end
                end
                age_d[tw] = '0;
            end
        end
    end

    always_comb begin
        ages    = '0;
        lru_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            ages[w*WAY_BITS +: WAY_BITS] = age_q[w];
            if (age_q[w] == WAY_BITS'(NUM_WAYS - 1)) begin
                lru_way = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                age_q[w] <= WAY_BITS'(w);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/cachemem_assoc.sv
// N-way set-associative line store: combinational lookups, one allocating write,
// one invalidate, true-LRU replacement and a registered dirty-victim channel.
module cachemem_assoc
    import cache_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned NUM_SETS     = 16,
    parameter int unsigned NUM_WAYS     = 4,
    parameter int unsigned DATA_BITS    = 64,
    parameter int unsigned TAG_BITS     = 25,
    localparam int unsigned IDX_BITS    = idx_bits(NUM_SETS),
    localparam int unsigned WAY_BITS    = way_bits(NUM_WAYS)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_RD_PORTS-1:0]          rd_en,
    input  logic [NUM_RD_PORTS*IDX_BITS-1:0] rd_idx,
    input  logic [NUM_RD_PORTS*TAG_BITS-1:0] rd_tag,
    output logic [NUM_RD_PORTS*DATA_BITS-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]          rd_hit,
    input  logic                             wr_en,
    input  logic [IDX_BITS-1:0]              wr_idx,
    input  logic [TAG_BITS-1:0]              wr_tag,
    input  logic [DATA_BITS-1:0]             wr_data,
    input  logic                             wr_dirty,
    input  logic                             inv_en,
    input  logic [IDX_BITS-1:0]              inv_idx,
    input  logic [TAG_BITS-1:0]              inv_tag,
    output logic                             evict_valid,
    output logic [IDX_BITS-1:0]              evict_idx,
    output logic [TAG_BITS-1:0]              evict_tag,
    output logic [DATA_BITS-1:0]             evict_data
);

    typedef struct packed {
        logic                 valid;
        logic                 dirty;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } cache_line_t;

    typedef struct packed {
        logic [IDX_BITS-1:0]  idx;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } evict_pkt_t;

    cache_line_t lines [NUM_SETS][NUM_WAYS];

    logic [WAY_BITS-1:0]          rd_way   [NUM_RD_PORTS];
    logic [NUM_WAYS*WAY_BITS-1:0] set_ages [NUM_SETS];
    logic [WAY_BITS-1:0]          set_lru  [NUM_SETS];

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [IDX_BITS-1:0]  idx;
        logic [TAG_BITS-1:0]  tag;
        logic                 match;
        logic [DATA_BITS-1:0] data;

        assign idx = rd_idx[p*IDX_BITS +: IDX_BITS];
        assign tag = rd_tag[p*TAG_BITS +: TAG_BITS];

        always_comb begin
            match     = 1'b0;
            data      = '0;
            rd_way[p] = '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (lines[idx][w].valid && lines[idx][w].tag == tag) begin
                    match     = 1'b1;
                    data      = lines[idx][w].data;
                    rd_way[p] = WAY_BITS'(w);
                end
            end
        end

        assign rd_hit[p] = rd_en[p] & match;
        assign rd_data[p*DATA_BITS +: DATA_BITS] = (rd_en[p] & match) ? data : '0;
    end

    logic                         wr_hit;
    logic [WAY_BITS-1:0]          wr_hit_way;
    logic                         inv_hit;
    logic [WAY_BITS-1:0]          inv_way;
    logic                         inv_apply;
    logic                         inv_excl;
    logic                         any_free;
    logic [WAY_BITS-1:0]          victim_way;
    logic [WAY_BITS-1:0]          wr_way;
    logic [NUM_WAYS*WAY_BITS-1:0] wr_ages;
    cache_line_t                  victim_line;
    logic                         evict_next;

    // An invalidate landing in the write's set this cycle removes its way from
    // victim candidacy; the next-oldest way (age NUM_WAYS-2) takes its place.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_way = '0;
        inv_hit    = 1'b0;
        inv_way    = '0;
        any_free   = 1'b0;
        victim_way = '0;
        wr_ages    = set_ages[wr_idx];
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (lines[wr_idx][w].valid && lines[wr_idx][w].tag == wr_tag) begin
                wr_hit     = 1'b1;
                wr_hit_way = WAY_BITS'(w);
            end
            if (lines[inv_idx][w].valid && lines[inv_idx][w].tag == inv_tag) begin
                inv_hit = 1'b1;
                inv_way = WAY_BITS'(w);
            end
            if (!any_free && !lines[wr_idx][w].valid) begin
                any_free   = 1'b1;
                victim_way = WAY_BITS'(w);
            end
        end
        inv_apply = inv_en && inv_hit &&
                    !(wr_en && wr_idx == inv_idx && wr_tag == inv_tag);
        inv_excl  = inv_apply && inv_idx == wr_idx;
        if (!any_free) begin
            victim_way = set_lru[wr_idx];
            if (inv_excl && victim_way == inv_way) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    if (wr_ages[w*WAY_BITS +: WAY_BITS] == WAY_BITS'(NUM_WAYS - 2)) begin
                        victim_way = WAY_BITS'(w);
                    end
                end
            end
        end
        wr_way      = wr_hit ? wr_hit_way : victim_way;
        victim_line = lines[wr_idx][victim_way];
        evict_next  = wr_en && !wr_hit && victim_line.valid && victim_line.dirty;
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        logic [NUM_RD_PORTS:0]            t_en;
        logic [(NUM_RD_PORTS+1)*WAY_BITS-1:0] t_way;

        always_comb begin
            t_en  = '0;
            t_way = '0;
            for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                t_en[p] = rd_hit[p] && (rd_idx[p*IDX_BITS +: IDX_BITS] == IDX_BITS'(s));
                t_way[p*WAY_BITS +: WAY_BITS] = rd_way[p];
            end
            t_en[NUM_RD_PORTS] = wr_en && (wr_idx == IDX_BITS'(s));
            t_way[NUM_RD_PORTS*WAY_BITS +: WAY_BITS] = wr_way;
        end

        lru_age_set #(
            .NUM_WAYS  (NUM_WAYS),
            .NUM_TOUCH (NUM_RD_PORTS + 1)
        ) u_lru (
            .clock     (clock),
            .reset     (reset),
            .touch_en  (t_en),
            .touch_way (t_way),
            .ages      (set_ages[s]),
            .lru_way   (set_lru[s])
        );
    end

    evict_pkt_t evict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    lines[s][w] <= '0;
                end
            end
            evict_valid <= 1'b0;
            evict_q     <= '0;
        end else begin
            if (inv_apply) begin
                lines[inv_idx][inv_way].valid <= 1'b0;
                lines[inv_idx][inv_way].dirty <= 1'b0;
            end
            if (wr_en) begin
                if (wr_hit) begin
                    lines[wr_idx][wr_way].data  <= wr_data;
                    lines[wr_idx][wr_way].dirty <= lines[wr_idx][wr_way].dirty | wr_dirty;
                end else begin
                    lines[wr_idx][wr_way] <= '{valid: 1'b1, dirty: wr_dirty,
                                               tag: wr_tag, data: wr_data};
                end
            end
            evict_valid <= evict_next;
            if (evict_next) begin
                evict_q <= '{idx: wr_idx, tag: victim_line.tag, data: victim_line.data};
            end
        end
    end

    assign evict_idx  = evict_q.idx;
    assign evict_tag  = evict_q.tag;
    assign evict_data = evict_q.data;

endmodule

// File: tb/tb_cachemem_assoc.sv
// Directed bench for cachemem_assoc with an array-level reference model.
module tb_cachemem_assoc;

    localparam int NR = 2;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int DB = 64;
    localparam int TB = 25;
    localparam int IB = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    rd_en;
    logic [NR*IB-1:0] rd_idx;
    logic [NR*TB-1:0] rd_tag;
    logic [NR*DB-1:0] rd_data;
    logic [NR-1:0]    rd_hit;
    logic             wr_en;
    logic [IB-1:0]    wr_idx;
    logic [TB-1:0]    wr_tag;
    logic [DB-1:0]    wr_data;
    logic             wr_dirty;
    logic             inv_en;
    logic [IB-1:0]    inv_idx;
    logic [TB-1:0]    inv_tag;
    logic             evict_valid;
    logic [IB-1:0]    evict_idx;
    logic [TB-1:0]    evict_tag;
    logic [DB-1:0]    evict_data;

    cachemem_assoc #(
        .NUM_RD_PORTS (NR),
        .NUM_SETS     (NS),
        .NUM_WAYS     (NW),
        .DATA_BITS    (DB),
        .TAG_BITS     (TB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .rd_hit      (rd_hit),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_tag      (wr_tag),
        .wr_data     (wr_data),
        .wr_dirty    (wr_dirty),
        .inv_en      (inv_en),
        .inv_idx     (inv_idx),
        .inv_tag     (inv_tag),
        .evict_valid (evict_valid),
        .evict_idx   (evict_idx),
        .evict_tag   (evict_tag),
        .evict_data  (evict_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays, ages as integers.
    bit        m_valid [NS][NW];
    bit        m_dirty [NS][NW];
    logic [TB-1:0] m_tag [NS][NW];
    logic [DB-1:0] m_data[NS][NW];
    int        m_age   [NS][NW];
    bit        m_ev_valid;
    logic [IB-1:0] m_ev_idx;
    logic [TB-1:0] m_ev_tag;
    logic [DB-1:0] m_ev_data;

    function automatic bit m_find(input int s, input logic [TB-1:0] t, output int way);
        way = 0;
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                way = w;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic m_touch(input int s, input int w);
        int a;
        a = m_age[s][w];
        for (int v = 0; v < NW; v++) if (m_age[s][v] < a) m_age[s][v]++;
        m_age[s][w] = 0;
    endtask

    task automatic model_step();
        int  ri[NR];
        int  rw[NR];
        bit  rh[NR];
        int  wi, ww, ii, iw, best;
        bit  wh, ih, ev;
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                for (int w = 0; w < NW; w++) begin
                    m_valid[s][w] = 0; m_dirty[s][w] = 0;
                    m_tag[s][w] = '0;  m_data[s][w] = '0;
                    m_age[s][w] = w;
                end
            end
            m_ev_valid = 0; m_ev_idx = '0; m_ev_tag = '0; m_ev_data = '0;
            return;
        end
        for (int p = 0; p < NR; p++) begin
            ri[p] = int'(rd_idx[p*IB +: IB]);
            rh[p] = rd_en[p] && m_find(ri[p], rd_tag[p*TB +: TB], rw[p]);
        end
        wi = int'(wr_idx);
        ii = int'(inv_idx);
        wh = wr_en && m_find(wi, wr_tag, ww);
        ih = inv_en && m_find(ii, inv_tag, iw);
        if (wr_en && inv_en && wr_idx == inv_idx && wr_tag == inv_tag) ih = 0;
        ev = 0;
        if (wr_en && !wh) begin
            ww = -1;
            for (int v = 0; v < NW; v++) begin
                if (ww < 0 && !m_valid[wi][v]) ww = v;
            end
            if (ww < 0) begin
                best = -1;
                for (int v = 0; v < NW; v++) begin
                    if (!(ih && ii == wi && v == iw) &&
                        (best < 0 || m_age[wi][v] > m_age[wi][best])) best = v;
                end
                ww = best;
            end
            if (m_valid[wi][ww] && m_dirty[wi][ww]) begin
                ev = 1;
                m_ev_idx  = wr_idx;
                m_ev_tag  = m_tag[wi][ww];
                m_ev_data = m_data[wi][ww];
            end
        end
        for (int p = 0; p < NR; p++) if (rh[p]) m_touch(ri[p], rw[p]);
        if (wr_en) m_touch(wi, ww);
        if (ih) begin
            m_valid[ii][iw] = 0;
            m_dirty[ii][iw] = 0;
        end
        if (wr_en) begin
            if (wh) begin
                m_data[wi][ww]  = wr_data;
                m_dirty[wi][ww] = m_dirty[wi][ww] | wr_dirty;
            end else begin
                m_valid[wi][ww] = 1; m_dirty[wi][ww] = wr_dirty;
                m_tag[wi][ww] = wr_tag; m_data[wi][ww] = wr_data;
            end
        end
        m_ev_valid = ev;
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (chk_on) begin
            for (int p = 0; p < NR; p++) begin
                int  w;
                bit  h;
                h = rd_en[p] && m_find(int'(rd_idx[p*IB +: IB]), rd_tag[p*TB +: TB], w);
                check($sformatf("model_rd_hit%0d", p), rd_hit[p], h);
                check($sformatf("model_rd_data%0d", p), rd_data[p*DB +: DB],
                      h ? m_data[int'(rd_idx[p*IB +: IB])][w] : 64'd0);
            end
            check("model_evict_valid", evict_valid, m_ev_valid);
            check("model_evict_idx", evict_idx, m_ev_idx);
            check("model_evict_tag", evict_tag, m_ev_tag);
            check("model_evict_data", evict_data, m_ev_data);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input int p, input logic [IB-1:0] idx, input logic [TB-1:0] tag);
        rd_en[p] = 1'b1;
        rd_idx[p*IB +: IB] = idx;
        rd_tag[p*TB +: TB] = tag;
    endtask

    task automatic do_wr(input logic [IB-1:0] idx, input logic [TB-1:0] tag,
                         input logic [DB-1:0] data, input logic dirty);
        wr_en = 1'b1; wr_idx = idx; wr_tag = tag; wr_data = data; wr_dirty = dirty;
        step();
        wr_en = 1'b0; wr_dirty = 1'b0;
    endtask

    logic [TB-1:0] exp_vic [4];

    initial begin
        reset = 1'b1; rd_en = '0; rd_idx = '0; rd_tag = '0;
        wr_en = 1'b0; wr_idx = '0; wr_tag = '0; wr_data = '0; wr_dirty = 1'b0;
        inv_en = 1'b0; inv_idx = '0; inv_tag = '0;
        step();
        chk_on = 1'b1;
        step();
        reset = 1'b0;

        // Reset state
        rd(0, 4'd3, 25'h10); rd(1, 4'd3, 25'h10); #1;
        check("reset_hit0", rd_hit[0], 0);
        check("reset_hit1", rd_hit[1], 0);
        check("reset_data0", rd_data[63:0], 0);
        check("reset_evict", evict_valid, 0);
        step(); rd_en = '0;

        // Clean fills in set 5, touch A, then B is the LRU victim
        for (int i = 0; i < 4; i++) do_wr(4'd5, 25'hA + TB'(i), 64'h10A + 64'(i), 1'b0);
        rd(0, 4'd5, 25'hA); step(); rd_en = '0;
        do_wr(4'd5, 25'hE, 64'h10E, 1'b0);
        check("clean_victim_no_evict", evict_valid, 0);
        rd(0, 4'd5, 25'hB); rd(1, 4'd5, 25'hA); #1;
        check("victim_b_gone", rd_hit[0], 0);
        check("a_kept", rd_hit[1], 1);
        check("a_data", rd_data[127:64], 64'h10A);
        step(); rd_en = '0;

        // Dirty victim in set 2
        do_wr(4'd2, 25'h1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        for (int i = 2; i < 5; i++) do_wr(4'd2, TB'(i), 64'(i), 1'b0);
        do_wr(4'd2, 25'h5, 64'h5, 1'b0);
        check("dirty_evict_valid", evict_valid, 1);
        check("dirty_evict_idx", evict_idx, 2);
        check("dirty_evict_tag", evict_tag, 25'h1);
        check("dirty_evict_data", evict_data, 64'hDEAD_BEEF_0000_0001);
        step();
        check("evict_pulse_ends", evict_valid, 0);
        check("evict_tag_holds", evict_tag, 25'h1);

        // Two read hits and a write hit composing in one cycle in set 9
        for (int i = 0; i < 4; i++) do_wr(4'd9, 25'h20 + TB'(i), 64'h900 + 64'(i), 1'b1);
        rd(0, 4'd9, 25'h20); rd(1, 4'd9, 25'h21);
        do_wr(4'd9, 25'h22, 64'h9FF, 1'b1);
        rd_en = '0;
        exp_vic = '{25'h23, 25'h20, 25'h21, 25'h22};
        for (int i = 0; i < 4; i++) begin
            do_wr(4'd9, 25'h30 + TB'(i), 64'h930 + 64'(i), 1'b0);
            check($sformatf("lru_order_valid%0d", i), evict_valid, 1);
            check($sformatf("lru_order_tag%0d", i), evict_tag, exp_vic[i]);
        end
        check("write_hit_data", evict_data, 64'h9FF);

        // Write and invalidate of the same line: write wins
        do_wr(4'd7, 25'h33, 64'h7000, 1'b1);
        inv_en = 1'b1; inv_idx = 4'd7; inv_tag = 25'h33;
        do_wr(4'd7, 25'h33, 64'h7001, 1'b0);
        inv_en = 1'b0;
        rd(0, 4'd7, 25'h33); #1;
        check("wr_inv_same_hit", rd_hit[0], 1);
        check("wr_inv_same_data", rd_data[63:0], 64'h7001);
        step(); rd_en = '0;
        inv_en = 1'b1; step(); inv_en = 1'b0;
        rd(0, 4'd7, 25'h33); #1;
        check("inv_dirty_miss", rd_hit[0], 0);
        check("inv_no_evict", evict_valid, 0);
        step(); rd_en = '0;

        // Invalidated way is not a victim candidate for a same-set write miss
        for (int i = 0; i < 4; i++) do_wr(4'd11, 25'h40 + TB'(i), 64'hB40 + 64'(i), 1'b1);
        inv_en = 1'b1; inv_idx = 4'd11; inv_tag = 25'h40;
        do_wr(4'd11, 25'h44, 64'hB44, 1'b0);
        inv_en = 1'b0;
        check("excl_evict_valid", evict_valid, 1);
        check("excl_evict_tag", evict_tag, 25'h41);
        rd(0, 4'd11, 25'h40); rd(1, 4'd11, 25'h44); #1;
        check("excl_inv_gone", rd_hit[0], 0);
        check("excl_new_hit", rd_hit[1], 1);
        step(); rd_en = '0;

        // Reset right after a dirty-victim write drops the pending pulse
        for (int i = 0; i < 4; i++) do_wr(4'd12, 25'h50 + TB'(i), 64'hC50 + 64'(i), 1'b1);
        do_wr(4'd12, 25'h54, 64'hC54, 1'b0);
        check("pre_reset_evict", evict_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_drops_evict", evict_valid, 0);
        rd(0, 4'd12, 25'h51); rd(1, 4'd5, 25'hA); #1;
        check("reset_clears0", rd_hit[0], 0);
        check("reset_clears1", rd_hit[1], 0);
        step(); rd_en = '0;
        step();

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
